// File: rtl/irq_timer_unit.sv
// Machine-level interrupt source: 64-bit mtime/mtimecmp timer, synchronised external line,
// and a held trap request to the CSR block that stays in service until MRET retires.
module irq_timer_unit #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
   parameter int unsigned PRESCALE  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        wr_en,
   input  logic        rd_en,
   output logic [31:0] rdata,
   input  logic        ext_irq,
   input  logic        glb_ie,
   input  logic        trap_ack,
   input  logic        is_mret,
   output logic        trap_req,
   output logic [31:0] trap_cause,
   output logic        in_service
);

   localparam logic [31:0] CauseExt = 32'h8000_000B;
   localparam logic [31:0] CauseTmr = 32'h8000_0007;
   localparam logic [15:0] PresMax  = 16'(PRESCALE - 1);

   typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

   state_e      state_q, state_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] rdata_q, rdata_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic [15:0] presc_q, presc_d;
   logic [2:0]  sync_q;
   logic        ext_pend_q, ext_pend_d;

   logic [31:0] off;
   logic        mapped, tick, ext_edge, timer_pend, eligible;
   logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_status;

   // Window is six aligned words; anything else decodes as unmapped.
   assign off    = addr - BASE_ADDR;
   assign mapped = (off < 32'h18) && (off[1:0] == 2'b00);

   assign wr_mtime_lo = wr_en && mapped && (off[4:2] == 3'd0);
   assign wr_mtime_hi = wr_en && mapped && (off[4:2] == 3'd1);
   assign wr_cmp_lo   = wr_en && mapped && (off[4:2] == 3'd2);
   assign wr_cmp_hi   = wr_en && mapped && (off[4:2] == 3'd3);
   assign wr_ctrl     = wr_en && mapped && (off[4:2] == 3'd4);
   assign wr_status   = wr_en && mapped && (off[4:2] == 3'd5);

   assign tick       = (presc_q == PresMax);
   assign ext_edge   = sync_q[1] & ~sync_q[2];
   assign timer_pend = (mtime_q >= mtimecmp_q);
   assign eligible   = glb_ie && ((ctrl_q[1] && ext_pend_q) || (ctrl_q[0] && timer_pend));

   always_comb begin
      presc_d    = tick ? 16'd0 : presc_q + 16'd1;
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      ctrl_d     = ctrl_q;
      // A software write to either mtime half suppresses that cycle's increment entirely.
      if (wr_mtime_lo || wr_mtime_hi) begin
         if (wr_mtime_lo) mtime_d[31:0]  = wdata;
         if (wr_mtime_hi) mtime_d[63:32] = wdata;
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
      if (wr_cmp_lo) mtimecmp_d[31:0]  = wdata;
      if (wr_cmp_hi) mtimecmp_d[63:32] = wdata;
      if (wr_ctrl)   ctrl_d            = wdata[1:0];
   end

   always_comb begin
      ext_pend_d = ext_pend_q;
      if (wr_status && wdata[1]) ext_pend_d = 1'b0;
      if ((state_q == StReq) && trap_ack && (cause_q == CauseExt)) ext_pend_d = 1'b0;
      if (ext_edge) ext_pend_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      unique case (state_q)
         StIdle: begin
            if (eligible) begin
               state_d = StReq;
               cause_d = (ctrl_q[1] && ext_pend_q) ? CauseExt : CauseTmr;
            end
         end
         StReq:     if (trap_ack) state_d = StService;
         StService: if (is_mret)  state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         rdata_d = '0;
         if (mapped) begin
            case (off[4:2])
               3'd0:    rdata_d = mtime_q[31:0];
               3'd1:    rdata_d = mtime_q[63:32];
               3'd2:    rdata_d = mtimecmp_q[31:0];
               3'd3:    rdata_d = mtimecmp_q[63:32];
               3'd4:    rdata_d = {30'd0, ctrl_q};
               3'd5:    rdata_d = {29'd0, (state_q == StService), ext_pend_q, timer_pend};
               default: rdata_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cause_q    <= '0;
         rdata_q    <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         ctrl_q     <= '0;
         presc_q    <= '0;
         sync_q     <= '0;
         ext_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         rdata_q    <= rdata_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         ctrl_q     <= ctrl_d;
         presc_q    <= presc_d;
         sync_q     <= {sync_q[1:0], ext_irq};
         ext_pend_q <= ext_pend_d;
      end
   end

   assign rdata      = rdata_q;
   assign trap_req   = (state_q == StReq);
   assign in_service = (state_q == StService);
   assign trap_cause = cause_q;

endmodule
